// File: rtl/voting_pkg.sv
// Shared definitions for the multi-candidate voting machine.
// Holds the controller state encoding and the default sizing parameters.
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/vote_button_sync.sv
// One-bit synchroniser plus registered rising-edge detector for a raw button or arm input.
// A bit that is already high when reset releases must be seen low before it can produce a press.
module vote_button_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic press
);

    logic s1, s2, s3;
    logic v1, v2;
    logic primed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            primed <= 1'b0;
            press  <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            s3     <= s2;
            // v2 marks s2 as holding a real sample rather than its reset value
            v1     <= 1'b1;
            v2     <= v1;
            primed <= primed | (v2 & ~s2);
            press  <= s2 & ~s3 & primed;
        end
    end

endmodule

// File: rtl/multi_candidate_voting_machine.sv
// Ballot controller: arm-gated single-vote acceptance, saturating per-candidate counters,
// running total, registered leader/tie tracking and result-mode count readout.
//
// state  | meaning
// IDLE   | waiting for an officer arm pulse
// ARMED  | one ballot may be cast; multi-presses are rejected
// RESULT | display mode, presses ignored, count_out shows count[sel]
module multi_candidate_voting_machine
    import voting_pkg::*;
#(
    parameter  int NUM_CAND = DEF_NUM_CAND,
    parameter  int CNT_W    = DEF_CNT_W,
    localparam int IDX_W    = $clog2(NUM_CAND),
    localparam int TOT_W    = CNT_W + IDX_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] button,
    input  logic [IDX_W-1:0]    sel,
    output logic                ready,
    output logic                vote_ack,
    output logic                vote_rej,
    output logic [CNT_W-1:0]    count_out,
    output logic [IDX_W-1:0]    winner,
    output logic                tie,
    output logic [TOT_W-1:0]    total,
    output logic                sat
);

    localparam logic [NUM_CAND-1:0] PRESS_ONE = NUM_CAND'(1);

    logic [NUM_CAND-1:0] press;
    logic                arm_press;
    logic                mode_s1, mode_s2;
    state_t              state;
    logic [CNT_W-1:0]    count [NUM_CAND];

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        vote_button_sync u_sync (
            .clock (clock),
            .reset (reset),
            .din   (button[g]),
            .press (press[g])
        );
    end

    vote_button_sync u_arm_sync (
        .clock (clock),
        .reset (reset),
        .din   (arm),
        .press (arm_press)
    );

    logic             multi, single, hit_max;
    logic [CNT_W-1:0] best, sel_count;
    logic [IDX_W-1:0] best_idx;
    logic             tie_c;

    always_comb begin
        multi     = (press & (press - PRESS_ONE)) != '0;
        single    = (press != '0) && !multi;
        hit_max   = 1'b0;
        sel_count = '0;
        best      = count[0];
        best_idx  = '0;
        tie_c     = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (press[i] && (count[i] == '1)) hit_max = 1'b1;
            if (sel == IDX_W'(i)) sel_count = count[i];
        end
        for (int i = 1; i < NUM_CAND; i++) begin
            if (count[i] > best) begin
                best     = count[i];
                best_idx = IDX_W'(i);
            end
        end
        // lowest index holds the lead; any other index at the same value is a tie
        for (int i = 0; i < NUM_CAND; i++) begin
            if ((count[i] == best) && (IDX_W'(i) != best_idx)) tie_c = 1'b1;
        end
    end

    assign ready = (state == ARMED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            vote_ack  <= 1'b0;
            vote_rej  <= 1'b0;
            count_out <= '0;
            winner    <= '0;
            tie       <= 1'b1;
            total     <= '0;
            sat       <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
        end else begin
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
            vote_ack  <= 1'b0;
            vote_rej  <= 1'b0;
            winner    <= best_idx;
            tie       <= tie_c;
            count_out <= (state == RESULT) ? sel_count : '0;
            if (mode_s2) begin
                state <= RESULT;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm_press) state <= ARMED;
                    end
                    ARMED: begin
                        if (single) begin
                            vote_ack <= 1'b1;
                            state    <= IDLE;
                            if (!hit_max) total <= total + TOT_W'(1);
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (press[i]) begin
                                    if (count[i] != '1) count[i] <= count[i] + CNT_W'(1);
                                    // upper bits all ones: counter is at or about to reach max
                                    if (&count[i][CNT_W-1:1]) sat <= 1'b1;
                                end
                            end
                        end else if (multi) begin
                            vote_rej <= 1'b1;
                        end
                    end
                    RESULT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_candidate_voting_machine.sv
// Directed bench for the voting machine (4 candidates, 4-bit counters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_multi_candidate_voting_machine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode  = 1'b0;
    logic       arm   = 1'b0;
    logic [3:0] button = '0;
    logic [1:0] sel   = '0;
    logic       ready, vote_ack, vote_rej, tie, sat;
    logic [3:0] count_out;
    logic [1:0] winner;
    logic [5:0] total;

    int n_cmp = 0;
    int n_bad = 0;
    int acks, rejs, ack_sum;
    logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0010, 4'b0001};

    multi_candidate_voting_machine #(.NUM_CAND(4), .CNT_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .arm       (arm),
        .button    (button),
        .sel       (sel),
        .ready     (ready),
        .vote_ack  (vote_ack),
        .vote_rej  (vote_rej),
        .count_out (count_out),
        .winner    (winner),
        .tie       (tie),
        .total     (total),
        .sat       (sat)
    );

    always #5 clock = ~clock;

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_ack"}, 32'(vote_ack), 0);
        chk({tag, "_rej"}, 32'(vote_rej), 0);
        chk({tag, "_cnt"}, 32'(count_out), 0);
        chk({tag, "_win"}, 32'(winner), 0);
        chk({tag, "_tie"}, 32'(tie), 1);
        chk({tag, "_tot"}, 32'(total), 0);
        chk({tag, "_sat"}, 32'(sat), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(3);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycles(6);
        arm = 1'b0;
        cycles(3);
    endtask

    task automatic do_vote(input logic [3:0] mask, output int na, output int nr);
        na = 0;
        nr = 0;
        button = mask;
        repeat (8) begin
            @(negedge clock);
            na += int'(vote_ack);
            nr += int'(vote_rej);
        end
        button = '0;
        repeat (4) begin
            @(negedge clock);
            na += int'(vote_ack);
            nr += int'(vote_rej);
        end
    endtask

    initial begin
        cycles(2);
        chk_reset_vals("rst0");
        reset = 1'b1;
        cycles(3);

        // single accepted vote for candidate 2
        do_arm();
        chk("arm_ready", 32'(ready), 1);
        do_vote(4'b0100, acks, rejs);
        chk("v2_ack", 32'(acks), 1);
        chk("v2_rej", 32'(rejs), 0);
        chk("v2_total", 32'(total), 1);
        chk("v2_ready", 32'(ready), 0);
        chk("v2_winner", 32'(winner), 2);
        chk("v2_tie", 32'(tie), 0);

        // presses without arm and in result mode are silent
        do_vote(4'b0010, acks, rejs);
        chk("noarm_ack", 32'(acks), 0);
        chk("noarm_rej", 32'(rejs), 0);
        mode = 1'b1;
        cycles(4);
        do_vote(4'b0010, acks, rejs);
        chk("res_ack", 32'(acks), 0);
        chk("res_rej", 32'(rejs), 0);
        sel = 2'd1;
        cycles(2);
        chk("res_cnt1", 32'(count_out), 0);
        sel = 2'd2;
        cycles(2);
        chk("res_cnt2", 32'(count_out), 1);
        chk("res_total", 32'(total), 1);
        mode = 1'b0;
        cycles(4);
        chk("idle_cnt", 32'(count_out), 0);

        // multi-press rejected, then a single press accepted
        do_arm();
        do_vote(4'b1001, acks, rejs);
        chk("multi_ack", 32'(acks), 0);
        chk("multi_rej", 32'(rejs), 1);
        chk("multi_ready", 32'(ready), 1);
        chk("multi_total", 32'(total), 1);
        do_vote(4'b1000, acks, rejs);
        chk("v3_ack", 32'(acks), 1);
        chk("v3_total", 32'(total), 2);
        chk("v3_ready", 32'(ready), 0);
        chk("v3_winner", 32'(winner), 2);
        chk("v3_tie", 32'(tie), 1);

        // reset while armed with non-zero counts
        do_arm();
        chk("pre_rst_ready", 32'(ready), 1);
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_armed");
        cycles(2);
        reset = 1'b1;
        cycles(3);
        do_vote(4'b0001, acks, rejs);
        chk("post_rst_ack", 32'(acks), 0);
        chk("post_rst_total", 32'(total), 0);
        chk("post_rst_ready", 32'(ready), 0);

        // button held through reset release does not vote
        reset = 1'b0;
        button = 4'b0001;
        cycles(2);
        reset = 1'b1;
        cycles(6);
        do_arm();
        chk("held_ready", 32'(ready), 1);
        chk("held_total", 32'(total), 0);
        button = '0;
        cycles(4);
        do_vote(4'b0001, acks, rejs);
        chk("held_then_ack", 32'(acks), 1);
        chk("held_then_total", 32'(total), 1);

        // votes 0,1,1,0 then readout
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_arm();
            do_vote(seq[k], acks, rejs);
            chk("seq_ack", 32'(acks), 1);
        end
        chk("seq_total", 32'(total), 4);
        chk("seq_winner", 32'(winner), 0);
        chk("seq_tie", 32'(tie), 1);
        mode = 1'b1;
        sel = 2'd2;
        cycles(5);
        chk("seq_cnt2", 32'(count_out), 0);
        sel = 2'd1;
        #1;
        chk("seq_cnt1_lat", 32'(count_out), 0);
        @(negedge clock);
        chk("seq_cnt1", 32'(count_out), 2);
        sel = 2'd0;
        cycles(1);
        chk("seq_cnt0", 32'(count_out), 2);
        mode = 1'b0;
        cycles(4);
        chk("seq_cnt_off", 32'(count_out), 0);

        // saturation with 4-bit counters
        do_reset();
        ack_sum = 0;
        for (int k = 1; k <= 17; k++) begin
            do_arm();
            do_vote(4'b0001, acks, rejs);
            ack_sum += acks;
            if (k == 14) begin
                chk("sat14_total", 32'(total), 14);
                chk("sat14_sat", 32'(sat), 0);
            end
        end
        chk("sat_acks", 32'(ack_sum), 17);
        chk("sat_total", 32'(total), 15);
        chk("sat_flag", 32'(sat), 1);
        chk("sat_winner", 32'(winner), 0);
        chk("sat_tie", 32'(tie), 0);
        mode = 1'b1;
        sel = 2'd0;
        cycles(5);
        chk("sat_cnt0", 32'(count_out), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
